// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch port and the data port.
// One transaction outstanding; data wins ties until a fetch has waited MAX_DPRIO grants.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_DPRIO = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imemreq_val,
    output logic              imemreq_rdy,
    input  logic [ADDR_W-1:0] imemreq_addr,
    output logic              imemresp_val,
    output logic [DATA_W-1:0] imemresp_data,
    input  logic              dmemreq_val,
    output logic              dmemreq_rdy,
    input  logic              dmemreq_type,
    input  logic [ADDR_W-1:0] dmemreq_addr,
    input  logic [DATA_W-1:0] dmemreq_wdata,
    output logic              dmemresp_val,
    output logic [DATA_W-1:0] dmemresp_rdata,
    output logic              memreq_val,
    input  logic              memreq_rdy,
    output logic              memreq_type,
    output logic [ADDR_W-1:0] memreq_addr,
    output logic [DATA_W-1:0] memreq_wdata,
    input  logic              memresp_val,
    input  logic [DATA_W-1:0] memresp_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_DPRIO);

    state_t     state_reg, state_next;
    logic       write_reg, write_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       idle;
    logic       grant_d;
    logic       fire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            write_reg <= 1'b0;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            write_reg <= write_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        write_next     = write_reg;
        cnt_next       = cnt_reg;
        memreq_type    = 1'b0;
        memreq_addr    = '0;
        memreq_wdata   = '0;
        imemreq_rdy    = 1'b0;
        dmemreq_rdy    = 1'b0;
        imemresp_val   = 1'b0;
        imemresp_data  = '0;
        dmemresp_val   = 1'b0;
        dmemresp_rdata = '0;

        idle    = (state_reg == IDLE);
        busy    = !idle;
        grant_d = dmemreq_val & (~imemreq_val | (cnt_reg < MAX_CNT));

        // Outputs are qualified by rst so everything reads 0 while reset is held
        memreq_val = rst & idle & (imemreq_val | dmemreq_val);
        fire       = memreq_val & memreq_rdy;

        if (memreq_val) begin
            if (grant_d) begin
                memreq_type  = dmemreq_type;
                memreq_addr  = dmemreq_addr;
                memreq_wdata = dmemreq_wdata;
                dmemreq_rdy  = memreq_rdy;
            end else begin
                memreq_addr  = imemreq_addr;
                imemreq_rdy  = memreq_rdy;
            end
        end

        case (state_reg)
            IDLE: begin
                if (!imemreq_val) begin
                    cnt_next = 4'd0;
                end else if (fire) begin
                    if (!grant_d)
                        cnt_next = 4'd0;
                    else if (cnt_reg < MAX_CNT)
                        cnt_next = cnt_reg + 4'd1;
                end
                if (fire) begin
                    state_next = grant_d ? WAIT_D : WAIT_I;
                    if (grant_d)
                        write_next = dmemreq_type;
                end
            end
            WAIT_I: begin
                if (memresp_val) begin
                    imemresp_val  = rst;
                    imemresp_data = memresp_rdata;
                    state_next    = IDLE;
                end
            end
            WAIT_D: begin
                if (memresp_val) begin
                    dmemresp_val   = rst;
                    dmemresp_rdata = write_reg ? '0 : memresp_rdata;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the TinyRV1 core's instruction-fetch port (read-only) and data port (read/write).
- Sits between Proc and the unified memory. It serialises requests with one transaction outstanding, routes each response back to its owner, and applies data-first priority with an anti-starvation limit for fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_DPRIO, 3, max consecutive data grants while a fetch is waiting; range 1..15

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
imemreq_val  input  1  fetch request valid
imemreq_rdy  output  1  fetch request accepted this cycle
imemreq_addr  input  ADDR_W  fetch address
imemresp_val  output  1  fetch response valid, one-cycle pulse
imemresp_data  output  DATA_W  fetch response data
dmemreq_val  input  1  data request valid
dmemreq_rdy  output  1  data request accepted this cycle
dmemreq_type  input  1  0 = read, 1 = write
dmemreq_addr  input  ADDR_W  data address
dmemreq_wdata  input  DATA_W  write data
dmemresp_val  output  1  data response valid, one-cycle pulse; also the write ack
dmemresp_rdata  output  DATA_W  read data; 0 for writes
memreq_val  output  1  downstream request valid
memreq_rdy  input  1  downstream can accept
memreq_type  output  1  0 = read, 1 = write
memreq_addr  output  ADDR_W  downstream address
memreq_wdata  output  DATA_W  downstream write data
memresp_val  input  1  downstream response valid
memresp_rdata  input  DATA_W  downstream read data
busy  output  1  transaction outstanding

Behaviour:
- States: IDLE, WAIT_I, WAIT_D. Registered: state, owner type bit, starvation counter cnt (4 bits).
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0.
  - All outputs 0 while rst=0, including the rdy signals.
  - An outstanding transaction is dropped. A memresp_val arriving after reset release while in IDLE is ignored.
- Grant selection in IDLE (combinational):
  - Only dmem valid → D. Only imem valid → I.
  - Both valid → D if cnt < MAX_DPRIO, else I.
- Request path in IDLE:
  - memreq_val = imemreq_val | dmemreq_val.
  - memreq_type/addr/wdata are muxed from the granted requester. For an I grant: type=0, wdata=0.
  - Granted requester's rdy = memreq_rdy. The other requester's rdy = 0.
- Accept:
  - A handshake fires when memreq_val & memreq_rdy in IDLE.
  - Next state: WAIT_D on a D grant, WAIT_I on an I grant. The write bit is latched for a D grant.
- Not in IDLE: memreq_val=0 and both rdy=0. Requesters must hold val/addr/wdata stable until their rdy.
- Response:
  - In WAIT_x, a memresp_val=1 cycle drives the owner's resp_val=1 for that same cycle (combinational pass-through of memresp_rdata; dresp data forced 0 if the latched write bit is set). Next state is IDLE.
  - The non-owner's resp_val stays 0.
  - Memory latency is unbounded: WAIT holds until memresp_val.
- Throughput: minimum 2 cycles per transaction (accept cycle, response cycle). No new request is accepted in the response cycle.
- Starvation counter cnt:
  - Accepted D grant while imemreq_val=1 → cnt+1, saturating at MAX_DPRIO.
  - Accepted I grant → cnt=0.
  - IDLE cycle with imemreq_val=0 → cnt=0.
  - Otherwise cnt holds.
- busy = (state != IDLE).
- Boundary conditions:
  - Both valid with memreq_rdy=0: grant is still computed but no state change; cnt unchanged.
  - memresp_val in IDLE: ignored, no resp pulse.
  - Reset asserted during WAIT: immediate return to IDLE; no resp pulse.

Test Plan:
1. Reset then single fetch: imemreq addr 0x200, memreq_rdy=1, memory returns 0x00500093 one cycle later. Required: memreq_addr=0x200 and type=0 in cycle 0; imemresp_val=1 with data 0x00500093 in cycle 1; dmemresp_val=0 throughout.
2. Data write then read: sw addr 0x1000 wdata 0xCAFEF00D. Required: dmemresp_val pulse with rdata 0. Then lw 0x1000 returns 0xCAFEF00D on dmemresp_rdata; imemreq_rdy=0 during both WAIT_D cycles.
3. Simultaneous requests, both held valid, MAX_DPRIO=3. Required: grant order D,D,D,I,D,D,D,I. cnt is 3 at each I grant and 0 immediately after.
4. Downstream backpressure: memreq_rdy=0 for 4 cycles with dmem valid. Required: dmemreq_rdy=0, memreq_val=1 with stable addr, state stays IDLE. On the first rdy=1 cycle, accept occurs; memory latency of 5 cycles keeps busy=1 for 5 cycles.
5. Reset mid-transaction: rst=0 in WAIT_I, memory responds 2 cycles after release. Required: all outputs 0 during reset, state IDLE, stale memresp_val produces no imemresp_val or dmemresp_val.
6. Spurious response: memresp_val=1 in IDLE with data 0xDEADBEEF. Required: no resp pulse; cnt and state unchanged.
